// File: rtl/lau_pkg.sv
// rtl/lau_pkg.sv - shared types for the modulo (2^n - 1) arithmetic units
package lau_pkg;

  typedef enum logic {FAST, SMALL} speed_e;

  typedef enum logic [1:0] {ACC_IDLE, ACC_RUN, ACC_DONE} acc_state_e;

endpackage

// File: rtl/add_mod_2nm1_s0.sv
// rtl/add_mod_2nm1_s0.sv - combinational adder modulo (2^n - 1), single zero representation
module AddMod2Nm1s0
  import lau_pkg::*;
#(
  parameter int     Width = 8,
  parameter speed_e Speed = FAST
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] s
);

  generate
    if (Speed == FAST) begin : g_fast
      // a+b+1 carries out exactly when a+b >= 2^n-1, so both sums run in parallel.
      logic [Width-1:0] sum0;
      logic [Width:0]   sum1;
      assign sum0 = a + b;
      assign sum1 = {1'b0, a} + {1'b0, b} + {{Width{1'b0}}, 1'b1};
      assign s    = sum1[Width] ? sum1[Width-1:0] : sum0;
    end else begin : g_small
      localparam logic [Width:0] Mod = {1'b0, {Width{1'b1}}};
      logic [Width:0] sum0;
      logic           wrap;
      assign sum0 = {1'b0, a} + {1'b0, b};
      assign wrap = (sum0 >= Mod);
      assign s    = wrap ? (sum0[Width-1:0] + {{(Width-1){1'b0}}, 1'b1}) : sum0[Width-1:0];
    end
  endgenerate

endmodule

// File: rtl/add_mod_2nm1_acc_ctrl.sv
// rtl/add_mod_2nm1_acc_ctrl.sv - streaming per-packet accumulator modulo (2^Width - 1)
module add_mod_2nm1_acc_ctrl
  import lau_pkg::*;
#(
  parameter int     Width    = 8,
  parameter speed_e Speed    = FAST,
  parameter int     CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [Width-1:0]    in_data_i,
  input  logic                in_valid_i,
  input  logic                in_last_i,
  output logic                in_ready_o,
  output logic [Width-1:0]    out_sum_o,
  output logic [CntWidth-1:0] out_count_o,
  output logic                out_sat_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o
);

  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  acc_state_e          state_q, state_d;
  logic [Width-1:0]    acc_q, acc_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [Width-1:0]    operand;
  logic [Width-1:0]    sum;
  logic                accept;

  // All-ones is the second encoding of zero; folding it keeps the adder output below 2^n-1.
  assign operand = (in_data_i == {Width{1'b1}}) ? {Width{1'b0}} : in_data_i;

  AddMod2Nm1s0 #(
    .Width(Width),
    .Speed(Speed)
  ) u_add (
    .a(acc_q),
    .b(operand),
    .s(sum)
  );

  assign in_ready_o  = (state_q != ACC_DONE) && !clear_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == ACC_DONE);
  assign out_sum_o   = acc_q;
  assign out_count_o = cnt_q;
  assign out_sat_o   = sat_q;
  assign busy_o      = (state_q != ACC_IDLE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clear_i) begin
      state_d = ACC_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ACC_IDLE: begin
          if (accept) begin
            acc_d   = sum;
            cnt_d   = CntOne;
            state_d = in_last_i ? ACC_DONE : ACC_RUN;
          end
        end
        ACC_RUN: begin
          if (accept) begin
            acc_d = sum;
            if (cnt_q == CntMax) sat_d = 1'b1;
            else                 cnt_d = cnt_q + CntOne;
            state_d = in_last_i ? ACC_DONE : ACC_RUN;
          end
        end
        ACC_DONE: begin
          if (out_ready_i) begin
            state_d = ACC_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: state_d = ACC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_add_mod_2nm1_acc_ctrl.sv
// tb/tb_add_mod_2nm1_acc_ctrl.sv - directed self-checking bench for add_mod_2nm1_acc_ctrl
module tb_add_mod_2nm1_acc_ctrl;
  import lau_pkg::*;

  logic       clk, rst_n, clear;
  logic [7:0] in_data;
  logic       in_valid, in_last, out_ready;
  logic       in_ready, out_sat, out_valid, busy;
  logic [7:0] out_sum, out_count;

  logic       clear2;
  logic [7:0] in_data2;
  logic       in_valid2, in_last2, out_ready2;
  logic       in_ready2, out_sat2, out_valid2, busy2;
  logic [7:0] out_sum2;
  logic [1:0] out_count2;

  int checks, failures;

  add_mod_2nm1_acc_ctrl #(.Width(8), .Speed(FAST), .CntWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
    .out_sum_o(out_sum), .out_count_o(out_count), .out_sat_o(out_sat),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
  );

  add_mod_2nm1_acc_ctrl #(.Width(8), .Speed(FAST), .CntWidth(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear2),
    .in_data_i(in_data2), .in_valid_i(in_valid2), .in_last_i(in_last2), .in_ready_o(in_ready2),
    .out_sum_o(out_sum2), .out_count_o(out_count2), .out_sat_o(out_sat2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready2), .busy_o(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    clear2 = 1'b0; in_data2 = '0; in_valid2 = 1'b0; in_last2 = 1'b0; out_ready2 = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0d exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if ({out_sum, out_count, out_sat} !== 17'd0) begin failures++; $display("FAIL reset_outputs sum=%0d cnt=%0d sat=%0d exp=0", out_sum, out_count, out_sat); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    beat(8'd200, 1'b0);
    beat(8'd100, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0d exp=1", out_valid); end
    checks++; if (out_sum !== 8'd45) begin failures++; $display("FAIL basic_sum got=%0d exp=45", out_sum); end
    checks++; if (out_count !== 8'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", out_count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_done_ready got=%0d exp=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_release valid=%0d busy=%0d exp=0,0", out_valid, busy); end
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    beat(8'd255, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_sum !== 8'd0 || out_count !== 8'd1) begin failures++; $display("FAIL zero_single sum=%0d cnt=%0d exp=0,1", out_sum, out_count); end
    step();
    beat(8'd254, 1'b0);
    beat(8'd1, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_sum !== 8'd0 || out_count !== 8'd2) begin failures++; $display("FAIL zero_wrap sum=%0d cnt=%0d exp=0,2", out_sum, out_count); end
    step();
  endtask

  task automatic test_random();
    int n, model;
    logic [7:0] d;
    out_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(1, 5);
      model = 0;
      for (int i = 0; i < n; i++) begin
        d = (i == 0 && p % 4 == 0) ? 8'd255 : 8'($urandom_range(0, 255));
        model = (model + int'(d)) % 255;
        beat(d, i == n - 1);
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'(model) || out_count !== 8'(n) || out_sum === 8'd255) begin
        failures++;
        $display("FAIL random_pkt%0d valid=%0d sum=%0d cnt=%0d exp=1,%0d,%0d", p, out_valid, out_sum, out_count, model, n);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(8'd17, 1'b0);
    beat(8'd34, 1'b0);
    beat(8'd51, 1'b1);
    in_data = 8'd9;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'd102 || out_count !== 8'd3) begin
        failures++;
        $display("FAIL bp_hold%0d ready=%0d valid=%0d sum=%0d cnt=%0d exp=0,1,102,3", c, in_ready, out_valid, out_sum, out_count);
      end
      if (c == 4) out_ready = 1'b1;
      step();
    end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 8'd0) begin failures++; $display("FAIL bp_release ready=%0d valid=%0d cnt=%0d exp=1,0,0", in_ready, out_valid, out_count); end
    step();
    in_valid = 1'b0;
    checks++; if (out_sum !== 8'd9 || out_count !== 8'd1) begin failures++; $display("FAIL bp_next_pkt sum=%0d cnt=%0d exp=9,1", out_sum, out_count); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    beat(8'd1, 1'b0);
    beat(8'd2, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_sum !== 8'd3 || out_count !== 8'd2) begin failures++; $display("FAIL b2b_first valid=%0d sum=%0d cnt=%0d exp=1,3,2", out_valid, out_sum, out_count); end
    in_data = 8'd3; in_last = 1'b1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall ready=%0d exp=0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_resume ready=%0d valid=%0d exp=1,0", in_ready, out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sum !== 8'd3 || out_count !== 8'd1) begin failures++; $display("FAIL b2b_second valid=%0d sum=%0d cnt=%0d exp=1,3,1", out_valid, out_sum, out_count); end
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_end valid=%0d busy=%0d exp=0,0", out_valid, busy); end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    beat(8'd100, 1'b0);
    beat(8'd100, 1'b0);
    checks++; if (busy !== 1'b1 || out_sum !== 8'd200) begin failures++; $display("FAIL clr_partial busy=%0d sum=%0d exp=1,200", busy, out_sum); end
    clear = 1'b1; in_data = 8'd7; in_last = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clr_ready got=%0d exp=0", in_ready); end
    step();
    clear = 1'b0;
    checks++; if (busy !== 1'b0 || out_sum !== 8'd0 || out_count !== 8'd0) begin failures++; $display("FAIL clr_flush busy=%0d sum=%0d cnt=%0d exp=0,0,0", busy, out_sum, out_count); end
    beat(8'd5, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sum !== 8'd5 || out_count !== 8'd1) begin failures++; $display("FAIL clr_after valid=%0d sum=%0d cnt=%0d exp=1,5,1", out_valid, out_sum, out_count); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 8'd0) begin failures++; $display("FAIL clr_done valid=%0d busy=%0d sum=%0d exp=0,0,0", out_valid, busy, out_sum); end
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_no_result valid=%0d exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    out_ready2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1; in_data2 = 8'd1; in_last2 = (i == 4);
      step();
    end
    in_valid2 = 1'b0;
    checks++; if (out_valid2 !== 1'b1 || out_count2 !== 2'd3 || out_sat2 !== 1'b1 || out_sum2 !== 8'd5) begin
      failures++; $display("FAIL sat_pkt valid=%0d cnt=%0d sat=%0d sum=%0d exp=1,3,1,5", out_valid2, out_count2, out_sat2, out_sum2);
    end
    out_ready2 = 1'b1;
    step();
    checks++; if (out_sat2 !== 1'b0 || out_count2 !== 2'd0) begin failures++; $display("FAIL sat_cleared sat=%0d cnt=%0d exp=0,0", out_sat2, out_count2); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    beat(8'd40, 1'b0);
    beat(8'd50, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_sum !== 8'd0 || out_count !== 8'd0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL areset sum=%0d cnt=%0d busy=%0d ready=%0d valid=%0d exp=0,0,0,1,0", out_sum, out_count, busy, in_ready, out_valid);
    end
    #2 rst_n = 1'b1;
    step();
    beat(8'd4, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_sum !== 8'd4 || out_count !== 8'd1) begin failures++; $display("FAIL areset_after sum=%0d cnt=%0d exp=4,1", out_sum, out_count); end
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_zero();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_mod_2nm1_acc_ctrl.md
Name: add_mod_2nm1_acc_ctrl

Overview:
Streaming multi-operand accumulator modulo (2^Width - 1), single zero representation. It sequences one shared AddMod2Nm1s0 datapath instance. Operands arrive on a valid/ready stream framed by a last flag; one residue per packet is returned on a valid/ready output. The block sits in front of checksum and residue-check logic (1's-complement sums, mod-3/15/255 residue codes).

Parameters:
Width, 8, operand/sum width n; modulus is 2^n - 1; Width >= 2.
Speed, lau_pkg::FAST, passed unchanged to the AddMod2Nm1s0 instance.
CntWidth, 8, width of the per-packet operand counter.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  reset, asynchronous, active-low.
clear_i  in  1  synchronous abort; discards the packet in flight.
in_data_i  in  Width  operand.
in_valid_i  in  1  operand valid.
in_last_i  in  1  operand is the last of its packet; qualified by in_valid_i.
in_ready_o  out  1  block accepts an operand this cycle.
out_sum_o  out  Width  packet sum mod (2^Width - 1); range 0 .. 2^Width-2.
out_count_o  out  CntWidth  operands in the packet, saturating.
out_sat_o  out  1  count saturated (packet longer than 2^CntWidth - 1).
out_valid_o  out  1  result valid.
out_ready_i  in  1  result consumer ready.
busy_o  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, acc=0, cnt=0, sat=0. All outputs 0 except in_ready_o=1.
- Operand normalisation: an operand equal to 2^Width-1 is mapped to 0 before the adder.
  - Together with acc < 2^Width-1, this guarantees the adder output is never all-ones.
- Datapath: a single AddMod2Nm1s0 with A=acc and B=norm(in_data_i). The adder is purely combinational.
  - acc <= S on each accepted beat. acc is 0 whenever state=IDLE.
- In-handshake: beat accepted when in_valid_i & in_ready_o.
  - in_ready_o = (state != DONE) & ~clear_i.
  - No combinational path from in_valid_i to in_ready_o.
- FSM:
  - IDLE: accepted beat -> acc=S, cnt=1. Next state is DONE if in_last_i, otherwise ACC.
  - ACC: accepted beat -> acc=S, cnt=cnt+1 (saturating; sat set when cnt would exceed max). Next state is DONE on in_last_i, otherwise stay.
  - DONE: out_valid_o=1. out_sum_o=acc, out_count_o=cnt, out_sat_o=sat, all driven directly from registers and stable while valid.
    - out_valid_o & out_ready_i -> IDLE, with acc, cnt, sat cleared.
- Latency: result valid the cycle after the last beat is accepted. Throughput is 1 operand/cycle.
- Packet overhead: minimum 1 dead input cycle per packet (the DONE cycle), even with out_ready_i held at 1.
- Single-beat packet: IDLE -> DONE directly; sum = norm(operand).
- Output backpressure: DONE holds indefinitely. in_ready_o stays 0 and no operand is consumed.
- clear_i (synchronous):
  - Overrides everything: next state=IDLE, acc=cnt=sat=0.
  - In DONE, the result is dropped without a handshake.
  - A beat presented in the same cycle is not accepted, since in_ready_o=0.
- Reset mid-packet: partial sum lost; the block is in IDLE on the first edge after deassertion.
- out_valid_o never drops without a handshake, except on clear_i or reset.

Decomposition:
- lau_pkg gains typedef enum logic [1:0] {ACC_IDLE, ACC_RUN, ACC_DONE} acc_state_e.
- The existing lau_pkg::speed_e is reused for Speed.
- One sub-module: the existing AddMod2Nm1s0 (Width, Speed). No new sub-module.
- The normalisation compare is inline.

Test Plan:
- Width=8. Packet {200,100(last)} with out_ready_i=1 -> out_valid_o 1 cycle after the last beat; sum=45, count=2.
- Packets {255(last)} and {254,1(last)} -> sum=0 for both (count 1 and 2). out_sum_o is never 255 under random stimulus; check against a reference model that sums integers mod 255.
- Packet {17,34,51(last)} with out_ready_i=0 for 5 cycles -> in_ready_o=0 and out_sum_o=102 stable throughout. Handshake on cycle 6; in_ready_o=1 the next cycle.
- Back-to-back packets {1,2(last)},{3(last)} with continuous in_valid_i -> results 3 then 3. Exactly one stall cycle between the packets; no beat lost or duplicated.
- clear_i asserted in ACC after {100,100}, then packet {5(last)} -> result sum=5, count=1. clear_i asserted in DONE -> out_valid_o falls next cycle and no result is emitted.
- CntWidth=2, packet of 5 ones -> count=3, out_sat_o=1, sum=5. Assert rst_ni=0 asynchronously mid-packet -> outputs 0 immediately, in_ready_o=1.
